data_mem_responder: RTL and testbench

//  Data-memory slave answering the load/store requests the core issues in its MEM_OP stage.

---
 rtl/data_mem_responder_pkg.sv | 60 ++++++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - memory instruction encoding, decode helpers and responder state type
package data_mem_responder_pkg;

    // bit3 = load, bit0 = unsigned, bits[2:1]: 11 byte, 01 half, 10 word.
    typedef enum logic [3:0] {
        MEM_NOP = 4'b0000,
        MEM_SH  = 4'b0010,
        MEM_SW  = 4'b0100,
        MEM_SB  = 4'b0110,
        MEM_LH  = 4'b1010,
        MEM_LHU = 4'b1011,
        MEM_LW  = 4'b1100,
        MEM_LB  = 4'b1110,
        MEM_LBU = 4'b1111
    } mem_inst_type_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_t;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_RESP
    } mem_rsp_state_t;

    function automatic logic mem_is_load(input mem_inst_type_t t);
        logic [3:0] b;
        b = t;
        return b[3];
    endfunction

    function automatic logic mem_is_unsigned(input mem_inst_type_t t);
        logic [3:0] b;
        b = t;
        return b[0];
    endfunction

    function automatic mem_size_t mem_size(input mem_inst_type_t t);
        logic [3:0] b;
        b = t;
        case (b[2:1])
            2'b11:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Only the nine named encodings are legal; anything else answers as an erroring NOP.
    function automatic logic mem_is_valid(input mem_inst_type_t t);
        case (t)
            MEM_NOP, MEM_SH, MEM_SW, MEM_SB,
            MEM_LH, MEM_LHU, MEM_LW, MEM_LB, MEM_LBU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane select plus extension for loads
// Ports: size/is_unsigned/lane describe the access; wdata is raw store data, rword the addressed
// RAM word. byte_en/wword feed the RAM write, rdata is the extended load result.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        byte_en = 4'b1111;
        wword   = wdata;
        rdata   = rword;
        rbyte   = rword[8*lane +: 8];
        rhalf   = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << lane;
                wword   = {4{wdata[7:0]}};
                rdata   = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                byte_en = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder with wait states and error flagging
// Ports: clk, rst_n (sync active-low); request req_valid/req_ready/req_type/req_addr/req_wdata;
// response rsp_valid/rsp_ready/rsp_rdata/rsp_err (held until rsp_ready).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    mem_rsp_state_t state_q, state_d;
    logic [3:0]     type_q, cnt_q;
    logic [31:0]    addr_q, wdata_q;
    logic           accept, enter_resp;
    logic [31:0]    mem [DEPTH_WORDS];

    assign req_ready = (state_q == RSP_IDLE);
    assign accept    = req_valid && req_ready;

    // With zero wait states the response is built on the accept edge itself,
    // so in IDLE the decode works straight off the request pins.
    logic [3:0]  cur_type;
    logic [31:0] cur_addr, cur_wdata;
    assign cur_type  = req_ready ? req_type  : type_q;
    assign cur_addr  = req_ready ? req_addr  : addr_q;
    assign cur_wdata = req_ready ? req_wdata : wdata_q;

    mem_inst_type_t cur_t;
    mem_size_t      size;
    logic           is_valid, is_nop, is_load, misaligned, out_of_range, fault, do_access;
    logic [31:0]    offset;
    logic [IW-1:0]  widx;

    assign cur_t        = mem_inst_type_t'(cur_type);
    assign size         = mem_size(cur_t);
    assign is_valid     = mem_is_valid(cur_t);
    assign is_load      = mem_is_load(cur_t);
    assign is_nop       = (cur_t == MEM_NOP);
    // Subtraction wraps, so addresses below BASE_ADDR land far above SPAN.
    assign offset       = cur_addr - BASE_ADDR;
    assign out_of_range = (offset >= SPAN);
    assign misaligned   = ((size == SZ_HALF) && offset[0]) ||
                          ((size == SZ_WORD) && (offset[1:0] != 2'b00));
    assign fault        = !is_valid || (!is_nop && (misaligned || out_of_range));
    assign do_access    = is_valid && !is_nop && !misaligned && !out_of_range;
    assign widx         = offset[IW+1:2];

    logic [3:0]  byte_en;
    logic [31:0] wword, ext_rdata;

    mem_lane_align u_lane_align (
        .size        (size),
        .is_unsigned (mem_is_unsigned(cur_t)),
        .lane        (offset[1:0]),
        .wdata       (cur_wdata),
        .rword       (mem[widx]),
        .byte_en     (byte_en),
        .wword       (wword),
        .rdata       (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RSP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            RSP_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = RSP_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = RSP_WAIT;
                    end
                end
            end
            RSP_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = RSP_RESP;
                    enter_resp = 1'b1;
                end
            end
            RSP_RESP: begin
                if (rsp_ready) begin
                    state_d = RSP_IDLE;
                end
            end
            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            cnt_q     <= 4'd0;
            type_q    <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
        end else begin
            if (accept) begin
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= WS;
            end else if (state_q == RSP_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= fault;
                rsp_rdata <= (do_access && is_load) ? ext_rdata : 32'h0;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // RAM is not reset; a reset edge still blocks the commit so a request caught in WAIT is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && do_access && !is_load) begin
            if (byte_en[0]) mem[widx][7:0]   <= wword[7:0];
            if (byte_en[1]) mem[widx][15:8]  <= wword[15:8];
            if (byte_en[2]) mem[widx][23:16] <= wword[23:16];
            if (byte_en[3]) mem[widx][31:24] <= wword[31:24];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam logic [3:0] T_NOP = 4'b0000, T_SH = 4'b0010, T_SW = 4'b0100, T_SB = 4'b0110;
    localparam logic [3:0] T_LH = 4'b1010, T_LHU = 4'b1011, T_LW = 4'b1100;
    localparam logic [3:0] T_LB = 4'b1110, T_LBU = 4'b1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [3:0]  req_type  [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    // Instance 0: 1 wait state, instance 1: 3 wait states, instance 2: 0 wait states at base 0x4000.
    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction
    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0000_4000 : 32'h0000_0000;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   ((g == 2) ? 32'h0000_4000 : 32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 3 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_type  (req_type[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mdl [3][4096];
    logic [31:0] exp_rd, got_rd;
    logic        exp_err, got_err;
    int          got_lat;

    // Reference: byte-addressed memory, access size in bytes, aligned-ness by modulo.
    task automatic model_op(input int d, input logic [3:0] t, input logic [31:0] a,
                            input logic [31:0] w, output logic [31:0] rd, output logic e);
        int n;
        bit ld, sx;
        logic [31:0] off, v;
        rd = 0; e = 0; n = 0; ld = 0; sx = 0; v = 0;
        off = a - base_of(d);
        case (t)
            T_LB:    begin n = 1; ld = 1; sx = 1; end
            T_LBU:   begin n = 1; ld = 1; end
            T_LH:    begin n = 2; ld = 1; sx = 1; end
            T_LHU:   begin n = 2; ld = 1; end
            T_LW:    begin n = 4; ld = 1; end
            T_SB:    n = 1;
            T_SH:    n = 2;
            T_SW:    n = 4;
            T_NOP:   n = 0;
            default: e = 1;
        endcase
        if (n != 0) begin
            if (off >= 32'(4 * DEPTH) || (off % 32'(n)) != 0) begin
                e = 1;
            end else if (ld) begin
                for (int i = 0; i < n; i++) v = v | (32'(mdl[d][off + 32'(i)]) << (8 * i));
                if (sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end else begin
                for (int i = 0; i < n; i++) mdl[d][off + 32'(i)] = w[8*i +: 8];
            end
        end
    endtask

    // One request/response; scrambles req_* after accept so later values must be ignored.
    task automatic xact(input int d, input logic [3:0] t, input logic [31:0] a, input logic [31:0] w);
        req_valid[d] = 1'b1; req_type[d] = t; req_addr[d] = a; req_wdata[d] = w;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_type[d] = 4'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
        got_lat = 1;
        while (rsp_valid[d] !== 1'b1 && got_lat < 40) begin
            @(posedge clk); #1;
            got_lat++;
        end
        got_rd  = rsp_rdata[d];
        got_err = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic run(input int d, input logic [3:0] t, input logic [31:0] a, input logic [31:0] w);
        model_op(d, t, a, w, exp_rd, exp_err);
        xact(d, t, a, w);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (req_ready[d] !== 1'b1) $display("FAIL reset_req_ready[%0d]: got %b want 1", d, req_ready[d]); else n_pass++;
            n_checks++; if (rsp_valid[d] !== 1'b0) $display("FAIL reset_rsp_valid[%0d]: got %b want 0", d, rsp_valid[d]); else n_pass++;
            n_checks++; if (rsp_rdata[d] !== 32'h0) $display("FAIL reset_rsp_rdata[%0d]: got %h want 0", d, rsp_rdata[d]); else n_pass++;
            n_checks++; if (rsp_err[d] !== 1'b0) $display("FAIL reset_rsp_err[%0d]: got %b want 0", d, rsp_err[d]); else n_pass++;
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        run(0, T_SW, 32'h10, 32'hDEADBEEF);
        n_checks++; if (got_err !== 1'b0) $display("FAIL sw_err: got %b want 0", got_err); else n_pass++;
        n_checks++; if (got_lat !== 2) $display("FAIL sw_latency: got %0d want 2", got_lat); else n_pass++;
        run(0, T_LW, 32'h10, 32'h0);
        n_checks++; if (got_rd !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h want deadbeef", got_rd); else n_pass++;
        n_checks++; if (got_err !== 1'b0) $display("FAIL lw_err: got %b want 0", got_err); else n_pass++;
        n_checks++; if (got_lat !== 2) $display("FAIL lw_latency: got %0d want 2", got_lat); else n_pass++;
    endtask

    task automatic test_byte_lanes();
        run(0, T_SB, 32'h11, 32'h0000_0080);
        run(0, T_LB, 32'h11, 32'h0);
        n_checks++; if (got_rd !== 32'hFFFFFF80) $display("FAIL lb_sext: got %h want ffffff80", got_rd); else n_pass++;
        run(0, T_LBU, 32'h11, 32'h0);
        n_checks++; if (got_rd !== 32'h00000080) $display("FAIL lbu_zext: got %h want 00000080", got_rd); else n_pass++;
        run(0, T_LW, 32'h10, 32'h0);
        n_checks++; if (got_rd !== 32'hDEAD80EF) $display("FAIL sb_lane: got %h want dead80ef", got_rd); else n_pass++;
        run(0, T_LH, 32'h12, 32'h0);
        n_checks++; if (got_rd !== 32'hFFFFDEAD) $display("FAIL lh_upper: got %h want ffffdead", got_rd); else n_pass++;
    endtask

    task automatic test_misaligned();
        run(0, T_LH, 32'h13, 32'h0);
        n_checks++; if (got_err !== 1'b1) $display("FAIL lh_misaligned_err: got %b want 1", got_err); else n_pass++;
        n_checks++; if (got_rd !== 32'h0) $display("FAIL lh_misaligned_rdata: got %h want 0", got_rd); else n_pass++;
        run(0, T_SW, 32'h12, 32'h1);
        n_checks++; if (got_err !== 1'b1) $display("FAIL sw_misaligned_err: got %b want 1", got_err); else n_pass++;
        run(0, T_LW, 32'h10, 32'h0);
        n_checks++; if (got_rd !== 32'hDEAD80EF) $display("FAIL sw_misaligned_nowrite: got %h want dead80ef", got_rd); else n_pass++;
    endtask

    task automatic test_out_of_range();
        for (int d = 0; d < 3; d += 2) begin
            run(d, T_LW, base_of(d) + 32'(4 * DEPTH), 32'h0);
            n_checks++; if (got_err !== 1'b1) $display("FAIL oor_high_err[%0d]: got %b want 1", d, got_err); else n_pass++;
            n_checks++; if (got_rd !== 32'h0) $display("FAIL oor_high_rdata[%0d]: got %h want 0", d, got_rd); else n_pass++;
            run(d, T_LW, base_of(d) - 32'd4, 32'h0);
            n_checks++; if (got_err !== 1'b1) $display("FAIL oor_low_err[%0d]: got %b want 1", d, got_err); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int k;
        req_valid[0] = 1'b1; req_type[0] = T_LW; req_addr[0] = 32'h10; req_wdata[0] = 32'h0;
        @(posedge clk); #1;
        // Present the next request early; it must wait until after the response handshake.
        req_type[0] = T_SW; req_addr[0] = 32'h30; req_wdata[0] = 32'hCAFEF00D;
        k = 0;
        while (rsp_valid[0] !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD80EF || req_ready[0] !== 1'b0)
                $display("FAIL hold_stable[%0d]: got valid=%b rdata=%h ready=%b want 1 dead80ef 0",
                         i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
            else n_pass++;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        n_checks++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) $display("FAIL after_handshake: got valid=%b ready=%b want 0 1", rsp_valid[0], req_ready[0]); else n_pass++;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++; if (req_ready[0] !== 1'b0) $display("FAIL pending_accept: got ready=%b want 0", req_ready[0]); else n_pass++;
        model_op(0, T_SW, 32'h30, 32'hCAFEF00D, exp_rd, exp_err);
        k = 0;
        while (rsp_valid[0] !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        run(0, T_LW, 32'h30, 32'h0);
        n_checks++; if (got_rd !== 32'hCAFEF00D) $display("FAIL pending_store: got %h want cafef00d", got_rd); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int k;
        run(1, T_SW, 32'h20, 32'hAAAA5555);
        n_checks++; if (got_lat !== 4) $display("FAIL ws3_latency: got %0d want 4", got_lat); else n_pass++;
        run(1, T_LW, 32'h20, 32'h0);
        n_checks++; if (got_rd !== 32'hAAAA5555) $display("FAIL ws3_lw: got %h want aaaa5555", got_rd); else n_pass++;
        req_valid[1] = 1'b1; req_type[1] = T_SW; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (req_ready[1] !== 1'b0) $display("FAIL in_wait_ready: got %b want 0", req_ready[1]); else n_pass++;
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0)
            $display("FAIL midwait_reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
        else n_pass++;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run(1, T_LW, 32'h20, 32'h0);
        n_checks++; if (got_rd !== 32'hAAAA5555) $display("FAIL dropped_store: got %h want aaaa5555", got_rd); else n_pass++;
        // A store that already reached RESP survives a reset before its handshake.
        req_valid[1] = 1'b1; req_type[1] = T_SW; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        k = 0;
        while (rsp_valid[1] !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        model_op(1, T_SW, 32'h20, 32'h12345678, exp_rd, exp_err);
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        run(1, T_LW, 32'h20, 32'h0);
        n_checks++; if (got_rd !== 32'h12345678) $display("FAIL committed_store: got %h want 12345678", got_rd); else n_pass++;
    endtask

    task automatic test_nop_zero_wait();
        run(2, T_SW, 32'h4000, 32'h5A5A5A5A);
        run(2, T_LW, 32'h4000, 32'h0);
        n_checks++; if (got_rd !== 32'h5A5A5A5A) $display("FAIL ws0_lw: got %h want 5a5a5a5a", got_rd); else n_pass++;
        n_checks++; if (got_lat !== 1) $display("FAIL ws0_lw_latency: got %0d want 1", got_lat); else n_pass++;
        run(2, T_NOP, 32'h4000, 32'hFFFFFFFF);
        n_checks++; if (got_lat !== 1) $display("FAIL nop_latency: got %0d want 1", got_lat); else n_pass++;
        n_checks++; if (got_rd !== 32'h0) $display("FAIL nop_rdata: got %h want 0", got_rd); else n_pass++;
        n_checks++; if (got_err !== 1'b0) $display("FAIL nop_err: got %b want 0", got_err); else n_pass++;
        run(2, 4'b0111, 32'h4000, 32'h0);
        n_checks++; if (got_err !== 1'b1) $display("FAIL illegal_type_err: got %b want 1", got_err); else n_pass++;
        run(2, T_LW, 32'h4000, 32'h0);
        n_checks++; if (got_rd !== 32'h5A5A5A5A) $display("FAIL nop_no_side_effect: got %h want 5a5a5a5a", got_rd); else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  tlist [11];
        logic [31:0] off;
        int          r;
        tlist = '{T_LB, T_LBU, T_LH, T_LHU, T_LW, T_SB, T_SH, T_SW, T_NOP, 4'b0111, 4'b1101};
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) run(d, T_SW, base_of(d) + 32'(4 * i), $urandom);
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      off = 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
                else if (r == 1) off = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                else             off = 32'($urandom_range(0, 63));
                run(d, tlist[$urandom_range(0, 10)], base_of(d) + off, $urandom);
                n_checks++; if (got_rd !== exp_rd) $display("FAIL rand_rdata[%0d.%0d]: got %h want %h", d, i, got_rd, exp_rd); else n_pass++;
                n_checks++; if (got_err !== exp_err) $display("FAIL rand_err[%0d.%0d]: got %b want %b", d, i, got_err, exp_err); else n_pass++;
                n_checks++; if (got_lat !== ws_of(d) + 1) $display("FAIL rand_latency[%0d.%0d]: got %0d want %0d", d, i, got_lat, ws_of(d) + 1); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_type[d] = 4'h0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_wait();
        test_nop_zero_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
